// File: rtl/data_mem_responder_pkg.sv
// Address map, status-word layout and decode helpers shared by the data-memory
// responder and anything that needs to talk to it.
package data_mem_responder_pkg;

  localparam logic [31:0] RAM_BASE            = 32'h0000_0000;
  localparam logic [31:0] CYCLE_ADDR          = 32'h8000_0000;
  localparam logic [31:0] CONSOLE_TX_ADDR     = 32'h8000_0004;
  localparam logic [31:0] CONSOLE_STATUS_ADDR = 32'h8000_0008;

  localparam int STATUS_FULL_BIT     = 0;
  localparam int STATUS_EMPTY_BIT    = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_COUNT_LSB    = 3;
  localparam int STATUS_COUNT_MSB    = 8;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_RAM,
    SEL_CYCLE,
    SEL_CONSOLE_TX,
    SEL_CONSOLE_STATUS
  } sel_e;

  // Byte offset within the word is ignored: all accesses are word aligned.
  function automatic logic word_match(input logic [31:0] addr, input logic [31:0] reg_addr);
    return addr[31:2] == reg_addr[31:2];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head word, sticky overflow flag and
// occupancy count. A push into a full FIFO is only accepted alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             pop_ok;
  logic             push_ok;
  logic [CW-1:0]    remain;
  logic [CW-1:0]    count_next;

  assign empty      = (count == '0);
  assign full       = (count == CW'(DEPTH));
  assign pop_ok     = pop & ~empty;
  assign push_ok    = push & (~full | pop_ok);
  assign remain     = count - CW'(pop_ok);
  assign count_next = remain + CW'(push_ok);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      head     <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_next;
      if (push && full && !pop_ok) begin
        overflow <= 1'b1;
      end
      // Head is the oldest surviving entry after this edge; when nothing older
      // survives, the incoming byte becomes the head directly.
      if (remain == '0) begin
        if (push_ok) begin
          head <= push_data;
        end
      end else begin
        head <= mem[rd_ptr + PW'(pop_ok)];
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-side memory for a single-cycle core: word RAM with combinational reads,
// a free-running cycle counter and a console TX byte FIFO behind MMIO registers.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int RAM_WORDS  = 256,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [31:0] address_to_mem,
  input  logic [31:0] data_to_mem,
  output logic [31:0] data_from_mem,
  output logic        console_valid,
  output logic [7:0]  console_data,
  input  logic        console_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]   ram [RAM_WORDS];
  logic [31:0]   cycle_count;
  logic [AW-1:0] word_index;
  sel_e          sel;
  logic [31:0]   status_word;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_overflow;
  logic [CW-1:0] fifo_count;
  logic          unused_addr_bits;

  assign word_index       = address_to_mem[AW+1:2];
  assign unused_addr_bits = &{1'b0, address_to_mem[1:0]};

  always_comb begin
    sel = SEL_NONE;
    if (address_to_mem[31:AW+2] == RAM_BASE[31:AW+2]) begin
      sel = SEL_RAM;
    end else if (word_match(address_to_mem, CYCLE_ADDR)) begin
      sel = SEL_CYCLE;
    end else if (word_match(address_to_mem, CONSOLE_TX_ADDR)) begin
      sel = SEL_CONSOLE_TX;
    end else if (word_match(address_to_mem, CONSOLE_STATUS_ADDR)) begin
      sel = SEL_CONSOLE_STATUS;
    end
  end

  always_comb begin
    status_word                                      = '0;
    status_word[STATUS_FULL_BIT]                     = fifo_full;
    status_word[STATUS_EMPTY_BIT]                    = fifo_empty;
    status_word[STATUS_OVERFLOW_BIT]                 = fifo_overflow;
    status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB]   = 6'(fifo_count);
  end

  // Reads are purely combinational and never disturb state.
  always_comb begin
    case (sel)
      SEL_RAM:            data_from_mem = ram[word_index];
      SEL_CYCLE:          data_from_mem = cycle_count;
      SEL_CONSOLE_STATUS: data_from_mem = status_word;
      default:            data_from_mem = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= 32'h0000_0000;
    end else begin
      cycle_count <= cycle_count + 32'd1;
    end
  end

  // RAM contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (WE && sel == SEL_RAM) begin
      ram[word_index] <= data_to_mem;
    end
  end

  // console_valid/console_ready: a byte transfers on every rising edge where
  // both are high; console_valid never depends on console_ready.
  assign fifo_push     = WE & (sel == SEL_CONSOLE_TX) & ~reset;
  assign fifo_pop      = console_valid & console_ready & ~reset;
  assign console_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (data_to_mem[7:0]),
    .pop       (fifo_pop),
    .head      (console_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .overflow  (fifo_overflow),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table vectors, directed FIFO/counter sequences
// and a random run checked against a queue/array model of the memory map.
module tb_data_mem_responder;

  localparam int          RAM_WORDS  = 256;
  localparam int          FIFO_DEPTH = 16;
  localparam logic [31:0] CYC_A      = 32'h8000_0000;
  localparam logic [31:0] TX_A       = 32'h8000_0004;
  localparam logic [31:0] ST_A       = 32'h8000_0008;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        cvalid;
  logic [7:0]  cdata;
  logic        cready;

  data_mem_responder #(
    .RAM_WORDS  (RAM_WORDS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .WE             (we),
    .address_to_mem (addr),
    .data_to_mem    (wdata),
    .data_from_mem  (rdata),
    .console_valid  (cvalid),
    .console_data   (cdata),
    .console_ready  (cready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard / model ----------------
  int          checks   = 0;
  int          failures = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] ram_m [RAM_WORDS];
  bit          ram_known [RAM_WORDS];
  logic [31:0] cyc_m;
  bit          ovf_m;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_m();
    return {23'd0, 6'(exp_q.size()), ovf_m, exp_q.size() == 0, exp_q.size() == FIFO_DEPTH};
  endfunction

  task automatic model_read(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v     = 32'h0;
    if (a < 32'(RAM_WORDS * 4)) begin
      v     = ram_m[a[9:2]];
      known = ram_known[a[9:2]];
    end else if (a[31:2] == CYC_A[31:2]) begin
      v = cyc_m;
    end else if (a[31:2] == ST_A[31:2]) begin
      v = status_m();
    end
  endtask

  task automatic model_update(input logic r, input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic rdy);
    bit popping;
    bit was_full;
    if (r) begin
      cyc_m = 32'h0;
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      cyc_m    = cyc_m + 32'd1;
      popping  = (exp_q.size() != 0) && rdy;
      was_full = (exp_q.size() == FIFO_DEPTH);
      if (w && a < 32'(RAM_WORDS * 4)) begin
        ram_m[a[9:2]]     = d;
        ram_known[a[9:2]] = 1'b1;
      end
      if (popping) void'(exp_q.pop_front());
      if (w && a[31:2] == TX_A[31:2]) begin
        if (was_full && !popping) ovf_m = 1'b1;
        else exp_q.push_back(d[7:0]);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    reset  = r;
    we     = w;
    addr   = a;
    wdata  = d;
    cready = rdy;
    #1;
  endtask

  task automatic clock_in();
    @(posedge clk);
    model_update(reset, we, addr, wdata, cready);
    #1;
  endtask

  task automatic model_check();
    logic [31:0] v;
    bit          known;
    model_read(addr, v, known);
    if (known) check("model read", rdata, v);
    check("model cvalid", 32'(cvalid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("model cdata", 32'(cdata), 32'(exp_q[0]));
  endtask

  task automatic step(input logic r, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic rdy);
    drive(r, w, a, d, rdy);
    model_check();
    clock_in();
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    string       name;
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    bit          chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input string n, input logic w, input logic [31:0] a,
                         input logic [31:0] d, input bit c, input logic [31:0] e);
    vec_t v;
    v.name = n; v.w = w; v.a = a; v.d = d; v.chk = c; v.exp = e;
    vecs.push_back(v);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [7:0] exp_bytes[$];
    bit         r;
    logic       w;
    logic       rdy;
    logic [31:0] a;
    logic [31:0] d;

    add_vec("store 0x10",        1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    add_vec("load 0x10",         1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add_vec("load 0x13",         1'b0, 32'h0000_0013, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add_vec("load unmapped",     1'b0, 32'h4000_0000, 32'h0,         1'b1, 32'h0);
    add_vec("store unmapped",    1'b1, 32'h4000_0000, 32'h1234_5678, 1'b1, 32'h0);
    add_vec("ram after unmapped",1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF);
    add_vec("unmapped reread",   1'b0, 32'h4000_0000, 32'h0,         1'b1, 32'h0);
    add_vec("load tx reg",       1'b0, TX_A,          32'h0,         1'b1, 32'h0);
    add_vec("store status ro",   1'b1, ST_A,          32'hFFFF_FFFF, 1'b1, 32'h2);
    add_vec("status after ro wr",1'b0, ST_A,          32'h0,         1'b1, 32'h2);
    add_vec("tx with we low",    1'b0, TX_A,          32'h0000_0077, 1'b1, 32'h0);
    add_vec("status no push",    1'b0, ST_A,          32'h0,         1'b1, 32'h2);
    add_vec("store top word",    1'b1, 32'h0000_03FC, 32'hA5A5_0F0F, 1'b0, 32'h0);
    add_vec("load top word",     1'b0, 32'h0000_03FC, 32'h0,         1'b1, 32'hA5A5_0F0F);
    add_vec("store word 0",      1'b1, 32'h0000_0000, 32'h0BAD_C0DE, 1'b0, 32'h0);
    add_vec("store past ram",    1'b1, 32'h0000_0400, 32'h1111_1111, 1'b1, 32'h0);
    add_vec("no alias word 0",   1'b0, 32'h0000_0000, 32'h0,         1'b1, 32'h0BAD_C0DE);
    add_vec("load past ram",     1'b0, 32'h0000_0400, 32'h0,         1'b1, 32'h0);

    // Reset: two cycles, then check reset state while still in reset.
    cyc_m = 32'h0;
    ovf_m = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
    clock_in();
    clock_in();
    drive(1'b1, 1'b0, CYC_A, 32'h0, 1'b0);
    check("reset cycle", rdata, 32'h0);
    check("reset cvalid", 32'(cvalid), 32'h0);
    check("reset cdata", 32'(cdata), 32'h0);
    drive(1'b1, 1'b0, ST_A, 32'h0, 1'b0);
    check("reset status", rdata, 32'h2);
    clock_in();

    // Cycle counter after release, then forced wrap.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, CYC_A, 32'h0, 1'b0);
    drive(1'b0, 1'b0, CYC_A, 32'h0, 1'b0);
    check("cycle after 5 idle", rdata, 32'd5);
    force dut.cycle_count = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count;
    cyc_m = 32'hFFFF_FFFF;
    check("cycle forced", rdata, 32'hFFFF_FFFF);
    clock_in();
    drive(1'b0, 1'b0, CYC_A, 32'h0, 1'b0);
    check("cycle wrap", rdata, 32'h0);
    clock_in();

    // Table-driven vectors.
    foreach (vecs[i]) begin
      drive(1'b0, vecs[i].w, vecs[i].a, vecs[i].d, 1'b0);
      if (vecs[i].chk) check(vecs[i].name, rdata, vecs[i].exp);
      clock_in();
    end

    // 17 pushes with the sink stalled: last byte overflows.
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, TX_A, 32'hFFFF_FF00 | (32'h41 + i), 1'b0);
    drive(1'b0, 1'b0, ST_A, 32'h0, 1'b0);
    check("status full ovf", rdata, 32'h85);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, ST_A, 32'h0, 1'b1);
      check("drain cvalid", 32'(cvalid), 32'h1);
      check("drain byte", 32'(cdata), 32'h41 + i);
      clock_in();
    end
    drive(1'b0, 1'b0, ST_A, 32'h0, 1'b0);
    check("status drained", rdata, 32'h6);
    check("drained cvalid", 32'(cvalid), 32'h0);
    step(1'b1, 1'b0, ST_A, 32'h0, 1'b0);

    // Full FIFO: push and pop in the same cycle.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, TX_A, 32'h60 + i, 1'b0);
    drive(1'b0, 1'b1, TX_A, 32'h0000_005A, 1'b1);
    check("full head", 32'(cdata), 32'h60);
    clock_in();
    drive(1'b0, 1'b0, ST_A, 32'h0, 1'b0);
    check("status push+pop full", rdata, 32'h81);
    exp_bytes.delete();
    for (int i = 1; i < 16; i++) exp_bytes.push_back(8'(8'h60 + i));
    exp_bytes.push_back(8'h5A);
    foreach (exp_bytes[i]) begin
      drive(1'b0, 1'b0, ST_A, 32'h0, 1'b1);
      check("push+pop drain", 32'(cdata), 32'(exp_bytes[i]));
      clock_in();
    end
    drive(1'b0, 1'b0, ST_A, 32'h0, 1'b0);
    check("status push+pop end", rdata, 32'h2);

    // Mid-stream reset discards FIFO, keeps RAM.
    step(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, TX_A, 32'h31 + i, 1'b0);
    step(1'b1, 1'b0, ST_A, 32'h0, 1'b0);
    drive(1'b0, 1'b0, ST_A, 32'h0, 1'b0);
    check("reset mid cvalid", 32'(cvalid), 32'h0);
    check("reset mid cdata", 32'(cdata), 32'h0);
    check("reset mid status", rdata, 32'h2);
    drive(1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0);
    check("ram survives reset", rdata, 32'hCAFE_F00D);
    clock_in();

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      r   = ($urandom_range(0, 99) == 0);
      rdy = ($urandom_range(0, 3) < ((n < 300) ? 1 : 3));
      w   = 1'b0;
      d   = $urandom;
      case ($urandom_range(0, 7))
        0:       begin w = 1'b1; a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))}; end
        1:       a = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(0, 3))};
        2, 3:    begin w = 1'b1; a = TX_A | 32'($urandom_range(0, 3)); end
        4:       a = ST_A;
        5:       a = CYC_A;
        6:       begin w = 1'($urandom_range(0, 1)); a = 32'h4000_0000 | $urandom; end
        default: begin
          w = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 2))
            0:       a = CYC_A;
            1:       a = ST_A;
            default: a = 32'h8000_000C + 32'($urandom_range(0, 64) * 4);
          endcase
        end
      endcase
      if (r) w = 1'b0;
      step(r, w, a, d, rdy);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter: RAM_WORDS, 256, number of 32-bit data RAM words (power of two).
REQ-002 Parameter: FIFO_DEPTH, 16, console TX FIFO entries (power of two, 2..32).
REQ-003 One clock; reset is synchronous and active-high; ports are clk and reset.
REQ-004 clk  input  1  rising-edge clock shared with the processor.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 WE  input  1  store strobe from the processor, sampled at rising clk.
REQ-007 address_to_mem  input  32  byte address for load or store.
REQ-008 data_to_mem  input  32  store data.
REQ-009 data_from_mem  output  32  load data, combinational from address_to_mem.
REQ-010 console_valid  output  1  TX FIFO non-empty.
REQ-011 console_data  output  8  TX FIFO head byte.
REQ-012 console_ready  input  1  sink accepts head byte when console_valid is high.

Function
REQ-013 Address map: RAM at 0x0000_0000 to (RAM_WORDS*4-1); CYCLE at 0x8000_0000 (RO); CONSOLE_TX at 0x8000_0004 (WO); CONSOLE_STATUS at 0x8000_0008 (RO).
REQ-014 Decode uses address_to_mem[1:0] ignored (word-aligned access only); RAM word index = address_to_mem[log2(RAM_WORDS)+1:2].
REQ-015 Read: data_from_mem combinational, zero latency, valid in the same cycle as the address (single-cycle processor requirement).
REQ-016 RAM write: when WE high at rising clk and address in the RAM range, the word is updated; the new value is readable from the next cycle.
REQ-017 Unmapped read returns 0x0000_0000; unmapped or RO-register write is ignored with no side effect.
REQ-018 CYCLE: 32-bit counter, +1 every clk not in reset, wraps 0xFFFF_FFFF -> 0; read returns the current registered value.
REQ-019 CONSOLE_TX write (WE high): pushes data_to_mem[7:0] into the TX FIFO; upper 24 bits are discarded.
REQ-020 CONSOLE_TX read returns 0.
REQ-021 CONSOLE_STATUS read: bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:3] occupancy count, other bits 0.
REQ-022 Pop occurs at rising clk when console_valid and console_ready are both high; console_data is registered FIFO head, first-in-first-out.
REQ-023 Push while full and no pop in the same cycle: byte dropped, overflow set, contents unchanged.
REQ-024 Push while full with a pop in the same cycle: both are accepted, count unchanged, overflow not set.
REQ-025 Push while empty: console_valid rises the next cycle; the same cycle cannot pop.
REQ-026 Read and write pointers wrap modulo FIFO_DEPTH; count range is 0..FIFO_DEPTH.
REQ-027 A store with WE low at a register address has no effect; reads never have side effects.

Reset
REQ-028 On reset: CYCLE=0, FIFO pointers/count=0, overflow=0, console_valid=0, console_data=0x00.
REQ-029 Reset does not clear RAM contents; a reset asserted mid-stream discards all FIFO contents at that edge.
REQ-030 A push or pop coinciding with reset is ignored.

Structure
REQ-031 A shared package holds the address-map constants (CYCLE_ADDR, CONSOLE_TX_ADDR, CONSOLE_STATUS_ADDR, RAM_BASE) and the status bit positions.
REQ-032 The TX FIFO is one sub-module, sync_fifo (parameterised width 8, depth FIFO_DEPTH, push/pop/full/empty/count); decode and RAM are in the top.

Verification
REQ-033 Store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 next cycle -> 0xDEADBEEF; load 0x0000_0013 -> 0xDEADBEEF.
REQ-034 Release reset, idle 5 cycles, load 0x8000_0000 -> 5; force count 0xFFFF_FFFF -> next cycle reads 0.
REQ-035 console_ready=0, push 17 bytes 0x41..0x51 -> STATUS reads full=1, count=16, overflow=1; drain with ready=1 -> bytes 0x41..0x50 in order, then empty=1.
REQ-036 FIFO full, push 0x5A while ready=1 in the same cycle -> count stays 16, overflow=0, 0x5A emerges last.
REQ-037 Load 0x4000_0000 -> 0; store to it, then RAM and status are unchanged.
REQ-038 Push 3 bytes, assert reset for one cycle -> console_valid=0, count=0, overflow=0, and previously stored RAM data is intact.
